seg7_scan_ctrl: RTL and testbench

Time-multiplexing scan controller for the 4-digit, 8-segment display on user IO pads 26–37. A Wishbone slave exposes digit patterns and control/status registers. A scan state machine drives one digit enable at a time, inserts dead time between digits to suppress ghosting, and applies PWM brightness within each digit slot. It sits in the user project wrapper between the Wishbone port and `io_out`/`io_oeb[37:26]`.

---
 rtl/seg7_pkg.sv | 26 ++
 rtl/seg7_wb_regs.sv | 105 ++++++++++
 rtl/seg7_scan_ctrl.sv | 140 ++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and types for the 4-digit seven-segment scan controller.
package seg7_pkg;

  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_CTRL   = 2'd1;
  localparam logic [1:0] OFF_STATUS = 2'd2;
  localparam logic [1:0] OFF_RSVD   = 2'd3;

  localparam int CTRL_EN         = 0;
  localparam int CTRL_POL        = 1;
  localparam int CTRL_BRIGHT_LSB = 8;

  localparam int STAT_DIGIT_LSB = 0;
  localparam int STAT_BUSY      = 2;
  localparam int STAT_FRAME_LSB = 8;

  localparam int IO_DIG_LSB = 0;
  localparam int IO_SEG_LSB = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DEAD = 2'd1,
    ST_ON   = 2'd2
  } scan_state_e;

endpackage

// File: rtl/seg7_wb_regs.sv
// Wishbone slave: address decode, single-cycle ack, DATA/CTRL registers and STATUS readback.
module seg7_wb_regs
  import seg7_pkg::*;
#(
  parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stb_i,
  input  logic        cyc_i,
  input  logic        we_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] dat_i,
  output logic        ack_o,
  output logic [31:0] dat_o,
  input  logic [1:0]  digit_i,
  input  logic        busy_i,
  input  logic [7:0]  frame_i,
  output logic [31:0] data_o,
  output logic        en_o,
  output logic        pol_o,
  output logic [7:0]  bright_o
);

  logic        ack_q;
  logic [31:0] dat_q, rd_d;
  logic [31:0] data_q, data_d;
  logic        en_q, en_d, pol_q, pol_d;
  logic [7:0]  bright_q, bright_d;
  logic        req, hit;
  logic [1:0]  off;
  logic        unused_adr;

  // Holding ack_q low for a cycle after each ack keeps acks from running back to back.
  assign req        = stb_i & cyc_i & ~ack_q;
  assign hit        = (adr_i[31:4] == BASE_ADR[31:4]);
  assign off        = adr_i[3:2];
  assign unused_adr = ^adr_i[1:0];

  always_comb begin
    rd_d = '0;
    if (hit) begin
      case (off)
        OFF_DATA:   rd_d = data_q;
        OFF_CTRL: begin
          rd_d[CTRL_EN]                       = en_q;
          rd_d[CTRL_POL]                      = pol_q;
          rd_d[CTRL_BRIGHT_LSB +: 8]          = bright_q;
        end
        OFF_STATUS: begin
          rd_d[STAT_DIGIT_LSB +: 2]           = digit_i;
          rd_d[STAT_BUSY]                     = busy_i;
          rd_d[STAT_FRAME_LSB +: 8]           = frame_i;
        end
        default:    rd_d = '0;
      endcase
    end
  end

  always_comb begin
    data_d   = data_q;
    en_d     = en_q;
    pol_d    = pol_q;
    bright_d = bright_q;
    if (req && we_i && hit) begin
      if (off == OFF_DATA) begin
        for (int i = 0; i < 4; i++)
          if (sel_i[i]) data_d[8*i +: 8] = dat_i[8*i +: 8];
      end else if (off == OFF_CTRL) begin
        if (sel_i[0]) begin
          en_d  = dat_i[CTRL_EN];
          pol_d = dat_i[CTRL_POL];
        end
        if (sel_i[1]) bright_d = dat_i[CTRL_BRIGHT_LSB +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      data_q   <= '0;
      en_q     <= 1'b0;
      pol_q    <= 1'b0;
      bright_q <= '0;
    end else begin
      ack_q    <= req;
      dat_q    <= req ? rd_d : '0;
      data_q   <= data_d;
      en_q     <= en_d;
      pol_q    <= pol_d;
      bright_q <= bright_d;
    end
  end

  assign ack_o    = ack_q;
  assign dat_o    = dat_q;
  assign data_o   = data_q;
  assign en_o     = en_q;
  assign pol_o    = pol_q;
  assign bright_o = bright_q;

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit display scanner: dead-time blanking, PWM brightness and registered pad outputs.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int          SCAN_DIV = 1000,
  parameter int          DEAD_CYC = 16,
  parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic [11:0] io_in,
  output logic [11:0] io_out,
  output logic [11:0] io_oeb
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYC - 1);
  localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(SCAN_DIV - DEAD_CYC - 1);

  scan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       digit_q, digit_d;
  logic [7:0]       pwm_q, pwm_d;
  logic [7:0]       frame_q, frame_d;
  logic [31:0]      shadow_q, shadow_d;
  logic [11:0]      io_out_q, io_out_d;
  logic [31:0]      data;
  logic             en, pol, lit;
  logic [7:0]       bright, seg_d;
  logic [3:0]       dig_d;
  logic             unused_io;

  assign unused_io = ^io_in;

  seg7_wb_regs #(.BASE_ADR(BASE_ADR)) u_regs (
    .clk_i    (wb_clk_i),
    .rst_i    (wb_rst_i),
    .stb_i    (wbs_stb_i),
    .cyc_i    (wbs_cyc_i),
    .we_i     (wbs_we_i),
    .sel_i    (wbs_sel_i),
    .adr_i    (wbs_adr_i),
    .dat_i    (wbs_dat_i),
    .ack_o    (wbs_ack_o),
    .dat_o    (wbs_dat_o),
    .digit_i  (digit_q),
    .busy_i   (state_q != ST_IDLE),
    .frame_i  (frame_q),
    .data_o   (data),
    .en_o     (en),
    .pol_o    (pol),
    .bright_o (bright)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    digit_d  = digit_q;
    pwm_d    = pwm_q;
    frame_d  = frame_q;
    shadow_d = shadow_q;
    if (!en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      digit_d = '0;
      pwm_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d  = ST_DEAD;
          cnt_d    = '0;
          digit_d  = '0;
          shadow_d = data;
        end
        ST_DEAD: begin
          if (cnt_q == DEAD_LAST) begin
            state_d = ST_ON;
            cnt_d   = '0;
            pwm_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_ON: begin
          if (cnt_q == ON_LAST) begin
            state_d  = ST_DEAD;
            cnt_d    = '0;
            digit_d  = digit_q + 2'd1;
            shadow_d = data;
            if (digit_q == 2'd3) frame_d = frame_q + 8'd1;
          end else begin
            cnt_d = cnt_q + 1'b1;
            pwm_d = pwm_q + 8'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Outputs are derived from next-state values so they line up with the state register.
    lit      = (state_d == ST_ON) && ((bright == 8'hFF) || (pwm_d < bright));
    dig_d    = lit ? (4'b0001 << digit_d) : 4'b0000;
    seg_d    = (state_d == ST_IDLE) ? 8'h00 : shadow_d[8*digit_d +: 8];
    io_out_d = '0;
    io_out_d[IO_SEG_LSB +: 8] = seg_d;
    io_out_d[IO_DIG_LSB +: 4] = dig_d ^ {4{pol}};
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      digit_q  <= '0;
      pwm_q    <= '0;
      frame_q  <= '0;
      shadow_q <= '0;
      io_out_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      digit_q  <= digit_d;
      pwm_q    <= pwm_d;
      frame_q  <= frame_d;
      shadow_q <= shadow_d;
      io_out_q <= io_out_d;
    end
  end

  assign io_out = io_out_q;
  assign io_oeb = '0;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with a per-cycle io_out scoreboard.
module tb_seg7_scan_ctrl;

  localparam int          SD   = 8;
  localparam int          DC   = 2;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, wdat = '0;
  logic        ack;
  logic [31:0] rdat;
  logic [11:0] io_in = '0;
  logic [11:0] io_out, io_oeb;

  int nchk = 0;
  int npass = 0;
  logic [11:0] expq[$];

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.SCAN_DIV(SD), .DEAD_CYC(DC), .BASE_ADR(BASE)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_stb_i (stb),
    .wbs_cyc_i (cyc),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (wdat),
    .wbs_ack_o (ack),
    .wbs_dat_o (rdat),
    .io_in     (io_in),
    .io_out    (io_out),
    .io_oeb    (io_oeb)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Called just after a clock edge; returns just after the acking edge.
  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] r, output int n);
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d; sel = s;
    r = '0; n = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        n = i;
        r = rdat;
        break;
      end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    chk("ack_seen", 32'(n != 0), 32'd1);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    int n;
    bus(1'b1, a, d, s, r, n);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] r, output int n);
    bus(1'b0, a, 32'h0, 4'hF, r, n);
  endtask

  // Expected io_out for slots s0..s0+n-1 of a scan starting at digit 0.
  task automatic push_slots(input logic [31:0] data, input int s0, input int n,
                            input logic [7:0] br, input logic pol);
    for (int s = s0; s < s0 + n; s++) begin
      int k;
      logic [7:0] seg;
      k   = s % 4;
      seg = data[8*k +: 8];
      for (int c = 0; c < SD; c++) begin
        logic [3:0] dig;
        dig = 4'h0;
        if (c >= DC && (br == 8'hFF || (c - DC) < int'(br))) dig = 4'(1 << k);
        if (pol) dig = ~dig;
        expq.push_back({seg, dig});
      end
    end
  endtask

  task automatic run_stream(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      logic [11:0] e;
      @(posedge clk); #1;
      e = (expq.size() > 0) ? expq.pop_front() : 12'hxxx;
      chk(tag, {20'h0, io_out}, {20'h0, e});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    int n;
    int acks;
    logic prev;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_io_out", {20'h0, io_out}, 32'h0);
    chk("rst_io_oeb", {20'h0, io_oeb}, 32'h0);
    chk("rst_ack", {31'h0, ack}, 32'h0);
    chk("rst_dat", rdat, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    rd(BASE + 32'h8, r, n); chk("rst_status", r, 32'h0);
    rd(BASE + 32'h0, r, n); chk("rst_data", r, 32'h0);
    rd(BASE + 32'h4, r, n); chk("rst_ctrl", r, 32'h0);

    // Full-brightness scan with a byte-select write during digit 1 ON.
    wr(BASE + 32'h0, 32'h4F5B063F, 4'hF);
    wr(BASE + 32'h4, 32'h0000FF01, 4'hF);
    push_slots(32'h4F5B063F, 0, 6, 8'hFF, 1'b0);
    push_slots(32'h4F5B773F, 6, 4, 8'hFF, 1'b0);
    fork
      run_stream(80, "scan_full");
      begin
        repeat (33) @(posedge clk);
        #1;
        rd(BASE + 32'h8, r, n); chk("status_frame1", r, 32'h0000_0104);
        repeat (9) @(posedge clk);
        #1;
        wr(BASE + 32'h0, 32'h0000_7700, 4'b0010);
        rd(BASE + 32'h0, r, n); chk("data_bytesel", r, 32'h4F5B773F);
      end
    join

    // Reset while digit 2 is lit.
    repeat (3) @(posedge clk);
    #1;
    chk("digit2_lit", {20'h0, io_out}, 32'h5B4);
    rst = 1'b1;
    #1;
    chk("rst_mid_io_out", {20'h0, io_out}, 32'h0);
    chk("rst_mid_ack", {31'h0, ack}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rd(BASE + 32'h8, r, n); chk("post_rst_status", r, 32'h0);
    rd(BASE + 32'h0, r, n); chk("post_rst_data", r, 32'h0);

    // Active-low enables with brightness 0, then 4/6 PWM.
    wr(BASE + 32'h0, 32'h4F5B063F, 4'hF);
    wr(BASE + 32'h4, 32'h0000_0003, 4'hF);
    push_slots(32'h4F5B063F, 0, 4, 8'h00, 1'b1);
    run_stream(32, "pol_off");
    wr(BASE + 32'h4, 32'h0, 4'hF);
    @(posedge clk); #1;
    chk("idle_off", {20'h0, io_out}, 32'h0);
    wr(BASE + 32'h4, 32'h0000_0401, 4'hF);
    push_slots(32'h4F5B063F, 0, 4, 8'h04, 1'b0);
    run_stream(32, "pwm4");

    // Clear EN during digit 0 DEAD.
    @(posedge clk); #1;
    wr(BASE + 32'h4, 32'h0, 4'hF);
    chk("dead_before_idle", {20'h0, io_out}, 32'h3F0);
    @(posedge clk); #1;
    chk("idle_after_clear", {20'h0, io_out}, 32'h0);
    rd(BASE + 32'h8, r, n);
    chk("status_busy_digit", r & 32'h7, 32'h0);
    chk("status_frame2", {24'h0, r[15:8]}, 32'h2);

    // Bus edge cases.
    @(posedge clk); #1;
    rd(BASE + 32'h20, r, n);
    chk("unmatched_rd_data", r, 32'h0);
    chk("unmatched_rd_latency", 32'(n), 32'd1);
    rd(BASE + 32'hC, r, n); chk("rsvd_rd", r, 32'h0);
    wr(BASE + 32'h20, 32'hFFFF_FFFF, 4'hF);
    wr(BASE + 32'h8, 32'hFFFF_FFFF, 4'hF);
    wr(BASE + 32'hC, 32'hFFFF_FFFF, 4'hF);
    rd(BASE + 32'h0, r, n); chk("data_untouched", r, 32'h4F5B063F);
    rd(BASE + 32'h4, r, n); chk("ctrl_untouched", r, 32'h0);

    @(posedge clk); #1;
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE + 32'h4;
    acks = 0;
    prev = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("no_b2b_ack", {31'h0, prev & ack}, 32'h0);
      acks += int'(ack);
      prev = ack;
    end
    stb = 1'b0; cyc = 1'b0;
    chk("ack_count", 32'(acks), 32'd5);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
